// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response channel.
// master = fetch front end, slave = instruction memory.
interface fetch_queue_if #(
   parameter int ADDRESS_BITS = 32
);
   logic                    imem_req_valid;
   logic [ADDRESS_BITS-1:0] imem_req_addr;
   logic                    imem_req_ready;
   logic                    imem_resp_valid;
   logic [31:0]             imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch into a DEPTH-entry {pc, inst}
// queue. Redirects flush the queue and drop responses still in flight.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the fetch_misalign flag,
// which halts fetch after a redirect to a non-word-aligned target.
module fetch_queue #(
   parameter int                      ADDRESS_BITS = 32,
   parameter int                      DEPTH        = 4,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   fetch_queue_if.master             imem,
   input  logic                      redirect_valid,
   input  logic [ADDRESS_BITS-1:0]   redirect_pc,
   input  logic                      fetch_stop,
   output logic                      out_valid,
   output logic [ADDRESS_BITS-1:0]   out_pc,
   output logic [31:0]               out_inst,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    occupancy
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic                      fetch_misalign
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           sh_wr_q, sh_wr_d, sh_rd_q, sh_rd_d;
   logic [CW-1:0]           count_q, count_d;
   logic [CW-1:0]           inflight_q, inflight_d;
   logic [CW-1:0]           drop_q, drop_d;

   logic [ADDRESS_BITS-1:0] pc_mem_q   [DEPTH];
   logic [31:0]             inst_mem_q [DEPTH];
   logic [ADDRESS_BITS-1:0] shpc_mem_q [DEPTH];

   logic                    accept, resp, push, pop, blocked;
   logic [CW:0]             live;
   logic [ADDRESS_BITS-1:0] redir_pc_al;

   // Entries already queued plus responses that will still be kept.
   assign live        = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
   assign redir_pc_al = redirect_pc & ~ADDRESS_BITS'(3);

   // inflight is also capped at DEPTH so the issue-PC shadow FIFO cannot
   // overrun while stale responses from a flushed stream are still pending.
   assign imem.imem_req_valid = rst && !redirect_valid && !fetch_stop && !blocked &&
                                (live < (CW+1)'(DEPTH)) && (inflight_q < CW'(DEPTH));
   assign imem.imem_req_addr  = fetch_pc_q;

   assign accept = imem.imem_req_valid && imem.imem_req_ready;
   assign resp   = imem.imem_resp_valid;

   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : '0;
   assign occupancy = count_q;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   // Every redirect re-evaluates alignment; aligned targets clear the flag.
   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid) misalign_d = |redirect_pc[1:0];
   end

   // Misalign flag register.
   always_ff @(posedge clk) begin
      if (!rst) misalign_q <= 1'b0;
      else      misalign_q <= misalign_d;
   end

   assign blocked        = misalign_q;
   assign fetch_misalign = misalign_q;
`else
   assign blocked = 1'b0;
`endif

   // Next-state for fetch PC, queue pointers and in-flight bookkeeping.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      sh_wr_d    = sh_wr_q;
      sh_rd_d    = sh_rd_q;
      count_d    = count_q;
      drop_d     = drop_q;
      push       = 1'b0;
      pop        = 1'b0;
      inflight_d = inflight_q + CW'(accept) - CW'(resp);
      if (accept) begin
         fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(4);
         sh_wr_d    = sh_wr_q + PW'(1);
      end
      // Every response retires one shadow entry, kept or dropped.
      if (resp) sh_rd_d = sh_rd_q + PW'(1);
      if (redirect_valid) begin
         // A response landing in the redirect cycle is stale too.
         fetch_pc_d = redir_pc_al;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         drop_d     = inflight_q - CW'(resp);
      end else begin
         if (resp) begin
            if (drop_q != '0) drop_d = drop_q - CW'(1);
            else              push   = 1'b1;
         end
         pop = out_valid && out_ready;
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sh_wr_q    <= '0;
         sh_rd_q    <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sh_wr_q    <= sh_wr_d;
         sh_rd_q    <= sh_rd_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Data storage: issue-PC shadow on accept, {pc, inst} queue on push.
   always_ff @(posedge clk) begin
      if (accept) shpc_mem_q[sh_wr_q] <= fetch_pc_q;
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= shpc_mem_q[sh_rd_q];
         inst_mem_q[wr_ptr_q] <= imem.imem_resp_data;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=4, RESET_PC=0) with
// a variable-latency in-order instruction memory model.
module tb_fetch_queue;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fetch_stop = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready = 1'b0;
   logic [2:0]  occupancy;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misalign;
`endif

   fetch_queue_if #(.ADDRESS_BITS(32)) imem_if ();

   fetch_queue #(.ADDRESS_BITS(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem_if),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_stop     (fetch_stop),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_ready      (out_ready),
      .occupancy      (occupancy)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   req_t        pend[$];
   logic [31:0] acc_addr[$];
   int          acc_cyc[$];
   logic [31:0] got[$];
   int          lat, cyc, acc_cnt, max_occ, first_pop_cyc;
   int          nvec = 0;
   int          nfail = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] got_at(input int i);
      return (got.size() > i) ? got[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      return (acc_addr.size() > i) ? acc_addr[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic int acc_cyc_at(input int i);
      return (acc_cyc.size() > i) ? acc_cyc[i] : -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock cycle: memory drives a due response, requests/pops are logged
   // mid-cycle, then time advances just past the rising edge.
   task automatic tick();
      imem_if.imem_resp_valid = 1'b0;
      imem_if.imem_resp_data  = '0;
      if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_if.imem_resp_valid = 1'b1;
         imem_if.imem_resp_data  = inst_of(pend[0].addr);
         void'(pend.pop_front());
      end
      @(negedge clk);
      if (rst) begin
         if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
            pend.push_back('{addr: imem_if.imem_req_addr, due: cyc + lat});
            acc_cnt++;
            acc_addr.push_back(imem_if.imem_req_addr);
            acc_cyc.push_back(cyc);
         end
         if (out_valid && out_ready && !redirect_valid) begin
            if (got.size() == 0) first_pop_cyc = cyc;
            got.push_back(out_pc);
            check("inst_pair", out_inst, inst_of(out_pc));
         end
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int latency);
      rst = 1'b0;
      redirect_valid = 1'b0;
      fetch_stop = 1'b0;
      pend.delete();
      tick();
      tick();
      check("rst_req_valid", 32'(imem_if.imem_req_valid), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
      acc_addr.delete();
      acc_cyc.delete();
      got.delete();
      acc_cnt = 0;
      max_occ = 0;
      first_pop_cyc = -1;
      lat = latency;
      cyc = 0;
      rst = 1'b1;
   endtask

   initial begin
      imem_if.imem_req_ready  = 1'b1;
      imem_if.imem_resp_valid = 1'b0;
      imem_if.imem_resp_data  = '0;
      lat = 1;
      cyc = 0;

      // Streaming with 1-cycle memory.
      do_reset(1);
      out_ready = 1'b1;
      repeat (12) tick();
      check("s1_first_pop_cyc", 32'(first_pop_cyc), 32'd2);
      check("s1_pops", 32'(got.size()), 32'd10);
      for (int i = 0; i < 10; i++) check("s1_pc", got_at(i), 32'(4 * i));
      check("s1_occ_le2", 32'(max_occ <= 2), 32'd1);

      // Decoder stalled: queue fills to DEPTH and requests stop.
      do_reset(1);
      out_ready = 1'b0;
      repeat (20) tick();
      check("s2_accepts", 32'(acc_cnt), 32'd4);
      check("s2_occupancy", 32'(occupancy), 32'd4);
      check("s2_req_valid", 32'(imem_if.imem_req_valid), 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && got.size() < 4; k++) tick();
      for (int i = 0; i < 4; i++) check("s2_pc", got_at(i), 32'(4 * i));

      // 3-cycle memory, redirect with three requests outstanding.
      do_reset(3);
      repeat (3) tick();
      check("s3_inflight", 32'(acc_cnt), 32'd3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      check("s3_out_valid_t1", 32'(out_valid), 32'd0);
      for (int k = 0; k < 40 && got.size() < 3; k++) tick();
      check("s3_req_addr", acc_at(3), 32'h100);
      check("s3_req_cyc", 32'(acc_cyc_at(3)), 32'd4);
      check("s3_pc0", got_at(0), 32'h100);
      check("s3_pc1", got_at(1), 32'h104);
      check("s3_pc2", got_at(2), 32'h108);

      // Redirect coinciding with a response and a pop.
      do_reset(1);
      out_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      check("s4_out_valid_t1", 32'(out_valid), 32'd0);
      check("s4_occ_t1", 32'(occupancy), 32'd0);
      for (int k = 0; k < 20 && got.size() < 3; k++) tick();
      check("s4_req_addr", acc_at(3), 32'h200);
      check("s4_req_cyc", 32'(acc_cyc_at(3)), 32'd4);
      check("s4_pc0", got_at(0), 32'h0);
      check("s4_pc1", got_at(1), 32'h200);
      check("s4_pc2", got_at(2), 32'h204);

      // fetch_stop with two in flight, then PC wrap past the top.
      do_reset(2);
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      fetch_stop = 1'b1;
      check("s5_inflight", 32'(acc_cnt), 32'd2);
      repeat (10) tick();
      check("s5_no_new_req", 32'(acc_cnt), 32'd2);
      check("s5_req_valid", 32'(imem_if.imem_req_valid), 32'd0);
      check("s5_pops", 32'(got.size()), 32'd2);
      check("s5_pc0", got_at(0), 32'hFFFF_FFF8);
      check("s5_pc1", got_at(1), 32'hFFFF_FFFC);
      fetch_stop = 1'b0;
      tick();
      check("s5_resume", 32'(acc_cnt), 32'd3);
      check("s5_wrap_addr", acc_at(2), 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned redirect halts fetch until an aligned redirect.
      do_reset(1);
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      tick();
      redirect_valid = 1'b0;
      check("s6_misalign_set", 32'(fetch_misalign), 32'd1);
      repeat (5) tick();
      check("s6_no_req", 32'(acc_cnt), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h104;
      tick();
      redirect_valid = 1'b0;
      check("s6_misalign_clr", 32'(fetch_misalign), 32'd0);
      tick();
      check("s6_resume_addr", acc_at(0), 32'h104);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
